// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed multi-digit 7-segment driver for a
// common-anode display. It latches packed BCD digits and decimal points, and
// swaps the shown value only at frame boundaries so a digit never changes
// mid-frame. It then drives one digit at a time onto shared active-low
// segment lines with active-low digit enables.
// Optional build macro: HEX_DECODE_EN. When it is defined, values 10-15 show
// as A b C d E F. When it is undefined, they are blanked.
module bcd_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;

  logic                    tc;
  logic                    wrap;
  logic [3:0]              digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;

  assign tc   = (div_cnt == CNT_MAX);
  assign wrap = tc && (idx == IDX_MAX);

  // Active-low segment decode, {g,f,e,d,c,b,a}. Each path assigns a value,
  // so the decode is fully specified in both builds.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
`ifdef HEX_DECODE_EN
      4'd10: s = 7'b0001000;
      4'd11: s = 7'b0000011;
      4'd12: s = 7'b1000110;
      4'd13: s = 7'b0100001;
      4'd14: s = 7'b0000110;
      4'd15: s = 7'b0001110;
`else
      default: s = 7'h7F;
`endif
    endcase
    return s;
  endfunction

  // Split the display register into digits. zero_above[k] is set when
  // digits k up to the top digit are all zero, which is the blanking test
  // for digit k.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi]      = disp_data[4*gi +: 4];
      assign zero_above[gi] = (disp_data[4*NUM_DIGITS-1:4*gi] == '0);
    end
  endgenerate

  // Select the digit being scanned and decide whether to blank it.
  // Digit 0 is never blanked.
  always_comb begin
    cur_digit = digit[idx];
    cur_dp    = disp_dp[idx];
    cur_blank = blank_lz && (idx != '0) && zero_above[idx];
  end

  // Prescaler and digit index. Each digit is enabled for REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tc) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Capture path. A load in the wrap cycle goes straight to the display
  // register. Otherwise the last pending load takes effect at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
    end else begin
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (wrap) begin
        pend_valid <= 1'b0;
        if (load) begin
          disp_data <= data_in;
          disp_dp   <= dp_in;
        end else if (pend_valid) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
        end
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // Output register. It reloads every cycle, so the pins show the current
  // idx one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= cur_blank ? 7'h7F : decode(cur_digit);
      dp         <= ~cur_dp;
      an         <= ~(NUM_DIGITS'(1) << idx);
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display with NUM_DIGITS=4 and REFRESH_DIV=4.
// The reference model works from the cycle count since reset release: the
// scanned digit is (cycle / REFRESH_DIV) mod NUM_DIGITS, and a frame wrap
// falls every NUM_DIGITS*REFRESH_DIV cycles. It holds the displayed value as
// a plain 16-bit number and compares every output pin on every cycle.
module tb_bcd_scan_display;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;

`ifdef HEX_DECODE_EN
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`else
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          blank_lz;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv;

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [6:0] exp_seg_f(input logic [15:0] d, input int k, input logic blz);
    logic [15:0] upper;
    upper = d >> (4 * k);
    if (blz && k != 0 && upper == 16'h0) return 7'h7F;
    return SEG_TAB[upper[3:0]];
  endfunction

  task automatic model_reset();
    cyc = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pv = 1'b0;
  endtask

  // One clock: drive inputs, predict the outputs, advance the model,
  // then check the outputs on the falling edge.
  task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic blz);
    int k;
    logic wr;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    load = ld; data_in = d; dp_in = p; blank_lz = blz;
    k     = (cyc / RD) % ND;
    wr    = ((cyc % FR) == FR - 1);
    e_an  = ~(4'b0001 << k);
    e_seg = exp_seg_f(m_disp, k, blz);
    e_dp  = ~m_dp[k];
    if (ld) $display("[TB] cyc=%0d load data=%h dp=%b wrap=%0d", cyc, d, p, wr);
    if (wr) begin
      if (ld) begin m_disp = d; m_dp = p; end
      else if (m_pv) begin m_disp = m_pend; m_dp = m_pdp; end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pend = d; m_pdp = p; m_pv = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("dp", {15'h0, dp}, {15'h0, e_dp});
    chk("frame_done", {15'h0, frame_done}, {15'h0, wr});
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0, blz);
  endtask

  task automatic idle_until(input int pos, input logic blz);
    for (int i = 0; i < FR && (cyc % FR) != pos; i++) tick(1'b0, 16'h0, 4'h0, blz);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, {9'h0, seg}, 16'h007F);
    chk({tag, "_dp"}, {15'h0, dp}, 16'h0001);
    chk({tag, "_an"}, {12'h0, an}, 16'h000F);
    chk({tag, "_fd"}, {15'h0, frame_done}, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; blank_lz = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Idle scan of a zeroed display: an rotates, frame_done every 16.
    idle(40, 1'b0);

    // Load in mid-frame, then watch the next frame.
    idle_until(6, 1'b0);
    tick(1'b1, 16'h1234, 4'h0, 1'b0);
    idle(2 * FR, 1'b0);

    // Two loads in the same frame: the last one wins.
    idle_until(2, 1'b0);
    tick(1'b1, 16'h1111, 4'h0, 1'b0);
    idle(3, 1'b0);
    tick(1'b1, 16'h5678, 4'h2, 1'b0);
    idle(FR + 8, 1'b0);

    // Load exactly on the wrap cycle.
    idle_until(FR - 1, 1'b0);
    tick(1'b1, 16'h9999, 4'h0, 1'b0);
    idle(FR, 1'b0);

    // Leading-zero blanking.
    tick(1'b1, 16'h0050, 4'h0, 1'b1);
    idle(2 * FR, 1'b1);
    tick(1'b1, 16'h0000, 4'h0, 1'b1);
    idle(2 * FR, 1'b1);

    // Hex value on digit 0 with its decimal point lit.
    tick(1'b1, 16'h000A, 4'b0001, 1'b0);
    idle(2 * FR, 1'b0);

    // Randomized traffic: sparse loads, blank_lz toggling.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in mid-frame: outputs return to reset values at once.
    idle_until(9, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(FR + 4, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
